// File: rtl/boot_loader.sv
// boot_loader: receives a byte-stream program image over valid/ready,
// assembles little-endian 32-bit words, writes them into main memory and
// then releases the core's reset after a short settling delay.
// Image format: 16-bit LE word count N, then 4*N data bytes.
// Optional: define BOOT_LOADER_CHECKSUM_EN to require a trailing byte C
// such that (sum of data bytes + C) mod 256 == 0.
module boot_loader #(
  parameter int ADDR_WIDTH    = 10,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  // Largest legal word count: the full memory.
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DELAY, S_RUN, S_ERR
`ifdef BOOT_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            byte_q, byte_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [7:0]            dly_q, dly_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            sum_chk;
  assign sum_chk = sum_q + in_data;
`endif

  logic        acc;
  logic [15:0] hdr_n;
  logic        last_word;

  assign acc       = in_valid & in_ready;
  assign hdr_n     = {in_data, cnt_q[7:0]};
  assign last_word = (17'(idx_q) + 17'd1) == {1'b0, cnt_q};

  // Outputs decode directly from registered state so they are glitch-free.
  assign in_ready   = reset & ((state_q == S_HDR0) | (state_q == S_HDR1) |
`ifdef BOOT_LOADER_CHECKSUM_EN
                               (state_q == S_CSUM) |
`endif
                               (state_q == S_DATA));
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_reset = (state_q != S_RUN);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERR);

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_HDR0;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dly_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dly_q   <= dly_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state logic: header parse, word assembly, write, release delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dly_d   = dly_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_HDR0: if (acc) begin
        cnt_d[7:0] = in_data;
        state_d    = S_HDR1;
      end
      S_HDR1: if (acc) begin
        cnt_d = hdr_n;
        if (hdr_n == 16'd0)
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DELAY;
`endif
        else if ({1'b0, hdr_n} > CAP) state_d = S_ERR;
        else                          state_d = S_DATA;
      end
      S_DATA: if (acc) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_d = sum_chk;
`endif
        if (byte_q == 2'd3) begin
          // Capture into the write registers so they hold after the pulse.
          wdata_d = {in_data, word_q};
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          byte_d  = 2'd0;
          state_d = S_WRITE;
        end else begin
          word_d[8*byte_q +: 8] = in_data;
          byte_d                = byte_q + 2'd1;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (last_word)
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DELAY;
`endif
        else
          state_d = S_DATA;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM: if (acc) begin
        state_d = (sum_chk == 8'd0) ? S_DELAY : S_ERR;
      end
`endif
      S_DELAY: begin
        if (dly_q == 8'(RELEASE_DELAY - 1)) state_d = S_RUN;
        else                                dly_d   = dly_q + 8'd1;
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR0;
    endcase
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream program-load stage for the single-cycle RISC-V top.
- Replaces the simulation-only memory preload: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into main memory through a write port, then releases the core's reset.
- The core stays in reset until the image is fully loaded and verified.

Parameters:
- ADDR_WIDTH, 10, word-address width of main memory; capacity is 2^ADDR_WIDTH words.
- RELEASE_DELAY, 4, cycles core_reset stays high after the last write before release; legal range 1-255.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  byte stream payload.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  main-memory word write enable.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  write data.
- core_reset  output  1  active-high reset to the core.
- done  output  1  image loaded, core running.
- error  output  1  load failed; sticky.

Behaviour:
- Reset: while reset is low, state goes to HDR0 immediately.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, in_ready=0.
  - Internal word count, index and byte counters clear to 0.
- Byte acceptance: a byte is accepted on the rising edge where in_valid & in_ready.
  - in_ready=1 only in HDR0, HDR1, DATA and CSUM, and only with reset high.
  - in_data is ignored otherwise.
- States:
  - HDR0: accept the count low byte -> HDR1.
  - HDR1: accept the count high byte (16-bit little-endian word count N).
    - N==0 -> DELAY.
    - N>2^ADDR_WIDTH -> ERR.
    - Otherwise -> DATA.
  - DATA: accept 4 bytes; byte k goes to word bits [8k+7:8k]. After the 4th byte -> WRITE.
  - WRITE: a single cycle with mem_we=1, mem_addr=index, mem_wdata=assembled word. Then index++.
    - If index+1==N -> CSUM (macro defined) or DELAY.
    - Otherwise -> DATA.
  - DELAY: counts RELEASE_DELAY cycles with core_reset=1, then -> RUN.
  - RUN: core_reset=0, done=1. Holds until reset.
  - ERR: core_reset=1, error=1, in_ready=0. Holds until reset.
- Latency and throughput:
  - The 4th byte accepted at edge N gives mem_we high during cycle N..N+1, and the next byte is accepted no earlier than edge N+2.
  - Peak throughput is 4 bytes per 5 cycles.
- Output timing:
  - mem_we is high for exactly one cycle per word.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Addressing: addresses are written strictly ascending from 0 to N-1, with no wrap. N==2^ADDR_WIDTH is legal and the last address is all ones.
- Stalls: in_valid low mid-word stalls without loss. Partial bytes are retained indefinitely.
- Extra bytes after the last word or checksum are not accepted (in_ready=0).
- Reset mid-load aborts at once: core_reset=1 and the partial word is discarded. Memory contents already written are not cleared.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum covers every DATA byte, excluding the header.
  - After the last WRITE the loader enters CSUM and accepts one byte C.
  - If (sum + C) mod 256 == 0 -> DELAY; otherwise -> ERR.
  - When N==0, CSUM is still required, with sum=0, so C must be 0x00.
- Undefined:
  - No CSUM state and no sum register; the last WRITE goes straight to DELAY.

Test Plan:
- Load N=2: bytes 02 00 | 93 04 50 01 | 73 00 10 00 -> writes addr0=0x01500493 and addr1=0x00100073, with mem_we pulsed exactly twice. core_reset falls 4 cycles after the 2nd write; done=1.
- Header 00 00 (no checksum build) -> no writes, RUN after 4 cycles. Checksum build: also send 00 -> RUN.
- Header 01 04 (N=1025, ADDR_WIDTH=10) -> ERR; error=1, core_reset=1, in_ready=0. Further bytes are ignored.
- Random in_valid gaps during the N=2 load -> identical writes and values. in_ready stays low in WRITE; no bytes are dropped or duplicated.
- Reset asserted after the 6th byte, then a full N=1 reload of 01 00 EF BE AD DE -> addr0=0xDEADBEEF. core_reset stays high throughout the abort.
- Checksum build, N=1, data 01 02 03 04 (sum 0x0A): C=0xF6 -> RUN; C=0xF5 -> ERR.
